// File: rtl/watch_mode_ctrl_pkg.sv
// Shared types for the two-key watch mode controller.
// Mode encoding, default clock rate and the digit mask helper.
package watch_pkg;

  typedef enum logic [1:0] {
    WATCH     = 2'd0,
    SET       = 2'd1,
    STOPWATCH = 2'd2
  } mode_t;

  localparam int unsigned IN_CLK_HZ_DEF = 50_000_000;

  function automatic logic [3:0] digit_mask(
    input logic [1:0] d
  );
    return 4'b0001 << d;
  endfunction

endpackage

// File: rtl/watch_mode_ctrl_key_hold_timer.sv
// Per-key hold counter: saturating press timer with
// reach-long pulse and short-release detect.
module key_hold_timer
  import watch_pkg::*;
#(
  parameter int unsigned LONG_CYC = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  output logic o_sat,
  output logic o_hit,
  output logic o_short
);

  localparam int unsigned CW = $clog2(LONG_CYC + 1);
  localparam logic [CW-1:0] C_LONG = CW'(LONG_CYC);
  localparam logic [CW-1:0] C_PRE = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  logic [CW-1:0] r_cnt;
  logic          r_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_hit <= 1'b0;
    end else begin
      r_hit <= i_key & (r_cnt == C_PRE);
      if (!i_key) begin
        r_cnt <= '0;
      end else if (r_cnt != C_LONG) begin
        r_cnt <= r_cnt + C_ONE;
      end
    end
  end

  // A nonzero count with the key low is the release cycle.
  assign o_sat   = (r_cnt == C_LONG);
  assign o_hit   = r_hit;
  assign o_short = ~i_key & (r_cnt != '0)
                 & (r_cnt != C_LONG);

endmodule

// File: rtl/watch_mode_ctrl.sv
// Two-key watch UI controller: key timing, chord lock,
// WATCH/SET/STOPWATCH mode FSM and SET digit blink.
module watch_mode_ctrl
  import watch_pkg::*;
#(
  parameter int unsigned IN_CLK_HZ = IN_CLK_HZ_DEF,
  parameter int unsigned LONG_MS   = 4000,
  parameter int unsigned BLINK_MS  = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_one,
  input  logic       key_two,
  output mode_t      mode,
  output logic       clk_run,
  output logic       show_sec,
  output logic [1:0] set_digit,
  output logic       set_inc,
  output logic       set_commit,
  output logic       sw_run,
  output logic       sw_clear,
  output logic [3:0] blank
);

  localparam int unsigned LONG_CYC =
    LONG_MS * (IN_CLK_HZ / 1000);
  localparam int unsigned BLINK_CYC =
    BLINK_MS * (IN_CLK_HZ / 1000);
  localparam int unsigned BW = $clog2(BLINK_CYC + 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_CYC - 1);
  localparam logic [BW-1:0] B_ONE = BW'(1);

  logic r_key1;
  logic r_key2;
  logic r_lock;

  mode_t      r_mode;
  logic       r_clk_run;
  logic       r_show_sec;
  logic [1:0] r_digit;
  logic       r_set_inc;
  logic       r_set_commit;
  logic       r_sw_run;
  logic       r_sw_clear;
  logic [3:0] r_blank;

  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;

  logic w_sat1;
  logic w_sat2;
  logic w_hit1;
  logic w_hit2;
  logic w_short1_raw;
  logic w_short2_raw;

  logic w_chord;
  logic w_long1;
  logic w_short1;
  logic w_short2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key1 <= 1'b0;
      r_key2 <= 1'b0;
    end else begin
      r_key1 <= key_one;
      r_key2 <= key_two;
    end
  end

  key_hold_timer #(
    .LONG_CYC(LONG_CYC)
  ) u_key1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_key  (r_key1),
    .o_sat  (w_sat1),
    .o_hit  (w_hit1),
    .o_short(w_short1_raw)
  );

  key_hold_timer #(
    .LONG_CYC(LONG_CYC)
  ) u_key2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_key  (r_key2),
    .o_sat  (w_sat2),
    .o_hit  (w_hit2),
    .o_short(w_short2_raw)
  );

  // Events are made mutually exclusive here:
  // chord, then long1, then short1, then short2.
  always_comb begin
    w_chord  = (w_hit1 | w_hit2) & w_sat1 & w_sat2
             & ~r_lock;
    w_long1  = w_hit1 & ~r_key2 & ~r_lock & ~w_chord;
    w_short1 = w_short1_raw & ~r_key2 & ~r_lock
             & ~w_chord & ~w_long1;
    w_short2 = w_short2_raw & ~r_key1 & ~r_lock
             & ~w_chord & ~w_long1 & ~w_short1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock <= 1'b0;
    end else if (w_chord) begin
      r_lock <= 1'b1;
    end else if (!r_key1 && !r_key2) begin
      r_lock <= 1'b0;
    end
  end

  // Blink defaults below equal the restart values,
  // so only the free-running SET tick overrides them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode       <= WATCH;
      r_clk_run    <= 1'b0;
      r_show_sec   <= 1'b0;
      r_digit      <= 2'd0;
      r_set_inc    <= 1'b0;
      r_set_commit <= 1'b0;
      r_sw_run     <= 1'b0;
      r_sw_clear   <= 1'b0;
      r_blank      <= 4'd0;
      r_blink_cnt  <= '0;
      r_phase      <= 1'b0;
    end else begin
      r_set_inc    <= 1'b0;
      r_set_commit <= 1'b0;
      r_sw_clear   <= 1'b0;
      r_show_sec   <= 1'b0;
      r_blink_cnt  <= '0;
      r_phase      <= 1'b0;
      r_blank      <= 4'd0;
      unique case (r_mode)
        WATCH: begin
          r_show_sec <= r_key2 & ~r_key1;
          unique case (1'b1)
            w_chord: begin
              r_mode <= STOPWATCH;
            end
            w_short1: begin
              r_mode    <= SET;
              r_digit   <= 2'd0;
              r_clk_run <= 1'b0;
            end
            default: ;
          endcase
        end
        SET: begin
          unique case (1'b1)
            w_long1: begin
              r_mode       <= WATCH;
              r_set_commit <= 1'b1;
              r_clk_run    <= 1'b1;
            end
            w_short1: begin
              r_digit <= r_digit + 2'd1;
            end
            w_short2: begin
              r_set_inc <= 1'b1;
            end
            default: begin
              if (r_blink_cnt == B_LAST) begin
                r_phase <= ~r_phase;
                r_blank <= r_phase ? 4'd0
                         : digit_mask(r_digit);
              end else begin
                r_blink_cnt <= r_blink_cnt + B_ONE;
                r_phase     <= r_phase;
                r_blank     <= r_blank;
              end
            end
          endcase
        end
        STOPWATCH: begin
          unique case (1'b1)
            w_chord: begin
              r_mode   <= WATCH;
              r_sw_run <= 1'b0;
            end
            w_short1: begin
              r_sw_clear <= 1'b1;
              r_sw_run   <= 1'b0;
            end
            w_short2: begin
              r_sw_run <= ~r_sw_run;
            end
            default: ;
          endcase
        end
        default: begin
          r_mode <= WATCH;
        end
      endcase
    end
  end

  assign mode       = r_mode;
  assign clk_run    = r_clk_run;
  assign show_sec   = r_show_sec;
  assign set_digit  = r_digit;
  assign set_inc    = r_set_inc;
  assign set_commit = r_set_commit;
  assign sw_run     = r_sw_run;
  assign sw_clear   = r_sw_clear;
  assign blank      = r_blank;

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Bench for watch_mode_ctrl: directed scenarios plus random
// key traffic against a press-duration reference model.
module tb_watch_mode_ctrl;
  import watch_pkg::*;

  localparam int L = 10;
  localparam int B = 4;

  logic       clk;
  logic       rst_n;
  logic       key_one;
  logic       key_two;
  mode_t      mode;
  logic       clk_run;
  logic       show_sec;
  logic [1:0] set_digit;
  logic       set_inc;
  logic       set_commit;
  logic       sw_run;
  logic       sw_clear;
  logic [3:0] blank;

  int n_chk;
  int n_bad;

  int m_q1, m_q2, m_run1, m_run2, m_lock;
  int m_mode, m_clk_run, m_show, m_digit;
  int m_inc, m_commit, m_swrun, m_clr, m_el;

  watch_mode_ctrl #(
    .IN_CLK_HZ(1000),
    .LONG_MS  (10),
    .BLINK_MS (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_one   (key_one),
    .key_two   (key_two),
    .mode      (mode),
    .clk_run   (clk_run),
    .show_sec  (show_sec),
    .set_digit (set_digit),
    .set_inc   (set_inc),
    .set_commit(set_commit),
    .sw_run    (sw_run),
    .sw_clear  (sw_clear),
    .blank     (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] outs();
    return {mode, clk_run, show_sec, set_digit,
            set_inc, set_commit, sw_run, sw_clear, blank};
  endfunction

  function automatic logic [13:0] m_outs();
    int bl;
    int md;
    int dg;
    bl = 0;
    if (m_mode == 1 && ((m_el / B) % 2) == 1)
      bl = 1 << m_digit;
    md = m_mode;
    dg = m_digit;
    return {md[1:0], m_clk_run[0], m_show[0], dg[1:0],
            m_inc[0], m_commit[0], m_swrun[0], m_clr[0],
            bl[3:0]};
  endfunction

  task automatic model_reset();
    m_q1 = 0; m_q2 = 0; m_run1 = 0; m_run2 = 0;
    m_lock = 0; m_mode = 0; m_clk_run = 0; m_show = 0;
    m_digit = 0; m_inc = 0; m_commit = 0; m_swrun = 0;
    m_clr = 0; m_el = 0;
  endtask

  // run = consecutive high cycles of the registered key,
  // counted without saturation.
  task automatic model_step();
    bit c, l1, s1, s2;
    c  = m_run1 >= L && m_run2 >= L && m_lock == 0;
    l1 = !c && m_run1 == L && m_q2 == 0 && m_lock == 0;
    s1 = !c && !l1 && m_q1 == 0 && m_run1 > 0
         && m_run1 < L && m_q2 == 0 && m_lock == 0;
    s2 = !c && !l1 && !s1 && m_q2 == 0 && m_run2 > 0
         && m_run2 < L && m_q1 == 0 && m_lock == 0;
    m_inc = 0; m_commit = 0; m_clr = 0;
    m_show = (m_mode == 0 && m_q2 == 1 && m_q1 == 0) ? 1 : 0;
    case (m_mode)
      0: begin
        if (c) m_mode = 2;
        else if (s1) begin
          m_mode = 1; m_digit = 0; m_clk_run = 0; m_el = 0;
        end
      end
      1: begin
        if (l1) begin
          m_mode = 0; m_commit = 1; m_clk_run = 1;
        end else if (s1) begin
          m_digit = (m_digit + 1) % 4; m_el = 0;
        end else if (s2) begin
          m_inc = 1; m_el = 0;
        end else m_el++;
      end
      default: begin
        if (c) begin
          m_mode = 0; m_swrun = 0;
        end else if (s1) begin
          m_clr = 1; m_swrun = 0;
        end else if (s2) m_swrun = 1 - m_swrun;
      end
    endcase
    if (c) m_lock = 1;
    else if (m_q1 == 0 && m_q2 == 0) m_lock = 0;
    m_run1 = m_q1 ? m_run1 + 1 : 0;
    m_run2 = m_q2 ? m_run2 + 1 : 0;
    m_q1 = key_one ? 1 : 0;
    m_q2 = key_two ? 1 : 0;
  endtask

  task automatic cyc(input logic a, input logic b);
    key_one = a;
    key_two = b;
    @(posedge clk);
    if (rst_n) model_step();
    #1 chk("outs", 32'(outs()), 32'(m_outs()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  task automatic tap1(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0);
    idle(2);
  endtask

  task automatic tap2(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1);
    idle(2);
  endtask

  task automatic chord(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1);
  endtask

  task automatic rst_pulse(input logic a, input logic b);
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk("rst_async", 32'(outs()), 32'd0);
    cyc(a, b);
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst_n = 1'b0;
    key_one = 1'b0;
    key_two = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk("reset", 32'(outs()), 32'd0);
    rst_n = 1'b1;

    tap1(3);
    chk("set_mode", 32'(mode), 32'd1);
    chk("set_digit0", 32'(set_digit), 32'd0);
    chk("clk_run0", 32'(clk_run), 32'd0);
    idle(4);
    chk("blink_on", 32'(blank), 32'd1);
    idle(4);
    chk("blink_off", 32'(blank), 32'd0);

    for (int d = 1; d <= 4; d++) begin
      tap1(2);
      chk("digit", 32'(set_digit), 32'(d % 4));
      chk("blink_rst", 32'(blank), 32'd0);
    end
    tap2(2);
    chk("inc_pulse", 32'(set_inc), 32'd1);
    idle(1);
    chk("inc_single", 32'(set_inc), 32'd0);
    idle(3);
    chk("blink_restart", 32'(blank), 32'd1);
    tap1(10);
    chk("commit", 32'(set_commit), 32'd1);
    chk("mode_watch", 32'(mode), 32'd0);
    chk("clk_run1", 32'(clk_run), 32'd1);
    idle(3);
    chk("commit_once", 32'(set_commit), 32'd0);
    chk("no_extra", 32'(mode), 32'd0);

    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    chk("show_sec", 32'(show_sec), 32'd1);
    idle(2);
    chk("show_sec_off", 32'(show_sec), 32'd0);
    chk("watch_stay", 32'(mode), 32'd0);

    chord(12);
    chk("chord_sw", 32'(mode), 32'd2);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
    idle(3);
    chk("chord_once", 32'(mode), 32'd2);
    chk("no_short_run", 32'(sw_run), 32'd0);

    tap2(2);
    chk("sw_run1", 32'(sw_run), 32'd1);
    tap2(2);
    chk("sw_run0", 32'(sw_run), 32'd0);
    tap2(2);
    tap1(2);
    chk("sw_clear", 32'(sw_clear), 32'd1);
    chk("sw_run_clr", 32'(sw_run), 32'd0);
    idle(1);
    chk("sw_clear_once", 32'(sw_clear), 32'd0);
    tap2(2);
    chord(12);
    chk("sw_exit", 32'(mode), 32'd0);
    chk("sw_run_off", 32'(sw_run), 32'd0);
    chk("clk_run_keep", 32'(clk_run), 32'd1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    idle(3);
    chk("rel_rev", 32'(mode), 32'd0);

    tap1(2);
    chk("set_again", 32'(mode), 32'd1);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk("rst_mid", 32'(outs()), 32'd0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    idle(2);
    chk("rst_short", 32'(mode), 32'd1);

    for (int s = 0; s < 300; s++) begin
      int p;
      int len;
      logic a, b;
      p = $urandom_range(0, 3);
      a = p[0];
      b = p[1];
      len = $urandom_range(1, 14);
      if ($urandom_range(0, 99) < 3) rst_pulse(a, b);
      for (int i = 0; i < len; i++) cyc(a, b);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/watch_mode_ctrl.md
WATCH_MODE_CTRL -- requirements
Module: watch_mode_ctrl

Interface
REQ-001 SHALL have parameter IN_CLK_HZ, default 50_000_000, clock frequency in Hz.
REQ-002 SHALL have parameter LONG_MS, default 4000, hold time that makes a long press or chord.
REQ-003 SHALL have parameter BLINK_MS, default 250, half-period of the digit blink in SET mode.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports key_one, key_two, input, 1 bit each: debounced key levels, active-high.
REQ-007 SHALL have port mode, output, mode_t (2 bits): WATCH=0, SET=1, STOPWATCH=2.
REQ-008 SHALL have port clk_run, output, 1 bit: enables time-of-day counting.
REQ-009 SHALL have port show_sec, output, 1 bit: WATCH display shows SS:cc instead of HH:MM.
REQ-010 SHALL have port set_digit, output, 2 bits: digit currently being edited.
REQ-011 SHALL have port set_inc, output, 1 bit: one-cycle pulse, increment digit set_digit.
REQ-012 SHALL have port set_commit, output, 1 bit: one-cycle pulse, load the edited time.
REQ-013 SHALL have port sw_run, output, 1 bit: stopwatch counting enable.
REQ-014 SHALL have port sw_clear, output, 1 bit: one-cycle pulse, zero the stopwatch.
REQ-015 SHALL have port blank, output, 4 bits: per-digit display blank mask.

Function
REQ-016 SHALL register key_one and key_two once before any use; all timing below counts from the registered level.
REQ-017 SHALL keep a hold counter per key that increments while its key is high, saturates at LONG_CYC = LONG_MS*(IN_CLK_HZ/1000), and clears on release; width is $clog2(LONG_CYC+1).
REQ-018 SHALL emit short event: key falls with count < LONG_CYC, other key low, chord_lock clear.
REQ-019 SHALL emit long event exactly once, in the cycle the count reaches LONG_CYC, provided the other key is low; releasing the key afterwards SHALL NOT produce a short event.
REQ-020 SHALL emit a chord event once when both counts are at LONG_CYC, then set chord_lock; while chord_lock is set, no short or long event SHALL be produced.
REQ-021 SHALL clear chord_lock only when both keys are low.
REQ-022 SHALL register all outputs; each output changes in the cycle after the event that causes it.
REQ-023 WATCH transitions:
- short1 -> SET, with set_digit=0 and clk_run=0.
- chord -> STOPWATCH.
- show_sec = key_two high and key_one low; otherwise 0.
REQ-024 SET transitions:
- short1 -> set_digit+1, wrapping 3 to 0.
- short2 -> set_inc pulse.
- long1 -> WATCH, with a set_commit pulse and clk_run=1.
- chord -> ignored.
REQ-025 STOPWATCH transitions:
- short2 -> toggle sw_run.
- short1 -> sw_clear pulse and sw_run=0.
- chord -> WATCH, with sw_run=0.
REQ-026 clk_run SHALL be left unchanged by the STOPWATCH transitions.
REQ-027 A blink counter SHALL toggle blink_phase every BLINK_CYC = BLINK_MS*(IN_CLK_HZ/1000) cycles in SET mode.
REQ-028 The blink counter SHALL restart with phase 0 (digit visible) on entering SET, on set_inc and on a set_digit change.
REQ-029 blank[set_digit] SHALL equal blink_phase in SET; blank SHALL be 0 in all other modes.
REQ-030 An illegal mode encoding SHALL return to WATCH on the next cycle with all pulses low.

Reset
REQ-031 Asserting rst_n=0 SHALL force, asynchronously:
- mode=WATCH, clk_run=0, show_sec=0, set_digit=0;
- set_inc=0, set_commit=0, sw_run=0, sw_clear=0, blank=0;
- both counters, chord_lock and the blink state to 0.
REQ-032 A reset asserted mid-press SHALL discard the press; a key still held at deassertion SHALL be timed from 0 and, if released before LONG_CYC, produce a short event.

Structure
REQ-033 Package watch_pkg SHALL hold mode_t and the IN_CLK_HZ default; LONG_CYC and BLINK_CYC are derived localparams in the module.
REQ-034 A sub-module key_hold_timer (the per-key counter, saturate flag and fall detect) SHALL be instantiated twice.

Verification (IN_CLK_HZ=1000, LONG_MS=10, BLINK_MS=4, so LONG_CYC=10 and BLINK_CYC=4)
REQ-035 Bench SHALL check: key_one high 3 cycles then low -> mode=SET, set_digit=0, clk_run=0, blank=0001 after 4 cycles, blank=0000 after 4 more.
REQ-036 Bench SHALL check: in SET, 4 short1 presses -> set_digit 1,2,3,0; short2 -> single set_inc pulse and blink restart; key_one held 10 cycles -> one set_commit pulse, mode=WATCH, clk_run=1; release gives no extra event.
REQ-037 Bench SHALL check: in WATCH, both keys held 12 cycles -> mode=STOPWATCH once; releasing in either order produces no short event.
REQ-038 Bench SHALL check: in STOPWATCH, short2 -> sw_run=1; short2 -> sw_run=0; short2 then short1 -> sw_clear pulse and sw_run=0; chord -> WATCH with sw_run=0 and clk_run unchanged.
REQ-039 Bench SHALL check: rst_n pulsed low while key_one is held 6 cycles in SET -> all outputs at reset values immediately; release 3 cycles after deassertion -> short1 -> SET.
